// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready skid stage (head + skid regs); CLK/RST_N, Flush squash, In_* upstream, Out_* downstream, Occupancy and saturating Stall_Count
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 4,
  parameter logic [DATA_W-1:0] FLUSH_PATTERN = {DATA_W/32{32'h2A2A_2A2A}},
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  Stall_Count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic in_fire, out_fire;
  assign In_Ready  = state != FULL;
  assign Out_Valid = state != EMPTY;
  assign Occupancy = state;
  assign in_fire   = In_Valid & In_Ready;
  assign out_fire  = Out_Valid & Out_Ready;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state       <= EMPTY;
      Out_Ctrl    <= '0;
      Out_Data    <= '0;
      skid_ctrl   <= '0;
      skid_data   <= '0;
      Stall_Count <= '0;
    end else begin
      if (Out_Valid && !Out_Ready && !Flush && Stall_Count != '1)
        Stall_Count <= Stall_Count + CNT_W'(1);
      if (Flush) begin
        state     <= EMPTY;
        Out_Ctrl  <= '0;
        Out_Data  <= FLUSH_PATTERN;
        skid_ctrl <= '0;
        skid_data <= '0;
      end else
        case (state)
          EMPTY: if (in_fire) begin
            state    <= ONE;
            Out_Ctrl <= In_Ctrl;
            Out_Data <= In_Data;
          end
          ONE: if (in_fire && out_fire) begin
            Out_Ctrl <= In_Ctrl;
            Out_Data <= In_Data;
          end else if (in_fire) begin
            state     <= FULL;
            skid_ctrl <= In_Ctrl;
            skid_data <= In_Data;
          end else if (out_fire) begin
            state    <= EMPTY;
            Out_Ctrl <= '0;
          end
          FULL: if (out_fire) begin
            state     <= ONE;
            Out_Ctrl  <= skid_ctrl;
            Out_Data  <= skid_data;
            skid_ctrl <= '0;
            skid_data <= '0;
          end
          default: state <= EMPTY;
        endcase
    end
endmodule
